// File: rtl/cpu6_clint_tmr.sv
// cpu6_clint_tmr -- machine-timer responder on the cpu6 data bus.
//
// Keeps a 64-bit mtime counter, advanced by a programmable prescaler, and
// compares it against a 64-bit mtimecmp.  The compare result, gated by the
// core's MTIE bit, is registered onto tmr_irq_r as a level interrupt.
//
// Register window (word offsets, decoded from dataaddr[4:2]):
//   0x00 mtime_lo     R/W     0x04 mtime_hi     R/W
//   0x08 mtimecmp_lo  R/W     0x0C mtimecmp_hi  R/W
//   0x10 ctrl         R/W  bit0 = EN, bits [8+PRESCALE_W-1:8] = DIV
//   0x14 status       RO   bit0 = mtime >= mtimecmp (ungated)
//   0x18, 0x1C        read 0, writes ignored
//
// Ports:
//   clk         clock, all state on the rising edge
//   reset       synchronous, active-low reset
//   sel         bus select for this window
//   dataaddr    byte address from the core
//   memwrite    store strobe
//   writedata   store data
//   readdata    combinational load data, 0 while sel is low
//   csr_mtie_r  mie.MTIE from the core
//   tmr_irq_r   registered timer interrupt to the core
module cpu6_clint_tmr #(
    parameter int CPU6_XLEN  = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel,
    input  logic [CPU6_XLEN-1:0] dataaddr,
    input  logic                 memwrite,
    input  logic [CPU6_XLEN-1:0] writedata,
    output logic [CPU6_XLEN-1:0] readdata,
    input  logic                 csr_mtie_r,
    output logic                 tmr_irq_r
);

    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic                  en_q, en_d;
    logic [PRESCALE_W-1:0] div_q, div_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic                  irq_q, irq_d;

    logic [2:0]  reg_idx;
    logic        wr_en;
    logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
    logic        pre_hit;
    logic        tick;
    logic        cmp_ge;
    logic [31:0] rd_word;

    // Address bits outside [4:2] are not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dataaddr[CPU6_XLEN-1:5], dataaddr[1:0]};

    always_comb begin
        reg_idx     = dataaddr[4:2];
        wr_en       = sel & memwrite;
        wr_mtime_lo = wr_en && (reg_idx == 3'd0);
        wr_mtime_hi = wr_en && (reg_idx == 3'd1);
        wr_cmp_lo   = wr_en && (reg_idx == 3'd2);
        wr_cmp_hi   = wr_en && (reg_idx == 3'd3);
        wr_ctrl     = wr_en && (reg_idx == 3'd4);

        cmp_ge  = (mtime_q >= mtimecmp_q);
        pre_hit = en_q && (pre_cnt_q == div_q);
        // A ctrl write restarts the prescaler and swallows this cycle's tick.
        tick    = pre_hit && !wr_ctrl;

        // Prescaler: a ctrl write wins; otherwise count while enabled.
        pre_cnt_d = pre_cnt_q;
        if (wr_ctrl) begin
            pre_cnt_d = '0;
        end else if (en_q) begin
            pre_cnt_d = pre_hit ? '0 : pre_cnt_q + 1'b1;
        end

        // mtime: a write to either half discards the tick for the whole
        // 64-bit counter, so a software load is never followed by a stray +1.
        mtime_d = mtime_q;
        if (tick && !wr_mtime_lo && !wr_mtime_hi) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wr_mtime_lo) begin
            mtime_d[31:0] = writedata[31:0];
        end
        if (wr_mtime_hi) begin
            mtime_d[63:32] = writedata[31:0];
        end

        mtimecmp_d = mtimecmp_q;
        if (wr_cmp_lo) begin
            mtimecmp_d[31:0] = writedata[31:0];
        end
        if (wr_cmp_hi) begin
            mtimecmp_d[63:32] = writedata[31:0];
        end

        en_d  = en_q;
        div_d = div_q;
        if (wr_ctrl) begin
            en_d  = writedata[0];
            div_d = writedata[8 +: PRESCALE_W];
        end

        // Compare uses pre-edge register values; MTIE gates only the irq.
        irq_d = cmp_ge & csr_mtie_r;

        rd_word = '0;
        case (reg_idx)
            3'd0: rd_word = mtime_q[31:0];
            3'd1: rd_word = mtime_q[63:32];
            3'd2: rd_word = mtimecmp_q[31:0];
            3'd3: rd_word = mtimecmp_q[63:32];
            3'd4: begin
                rd_word[0]              = en_q;
                rd_word[8 +: PRESCALE_W] = div_q;
            end
            3'd5: rd_word[0] = cmp_ge;
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            en_q       <= 1'b0;
            div_q      <= '0;
            pre_cnt_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            div_q      <= div_d;
            pre_cnt_q  <= pre_cnt_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata  = sel ? CPU6_XLEN'(rd_word) : '0;
    assign tmr_irq_r = irq_q;

endmodule

// File: tb/tb_cpu6_clint_tmr.sv
// Testbench for cpu6_clint_tmr.  Stimulus pushes expected values, tagged with
// the cycle in which they must hold, into a queue; a monitor on the falling
// edge pops and compares them against readdata / tmr_irq_r.
module tb_cpu6_clint_tmr;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [31:0] dataaddr;
    logic        memwrite;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        csr_mtie_r;
    logic        tmr_irq_r;

    cpu6_clint_tmr #(.CPU6_XLEN(32), .PRESCALE_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .dataaddr   (dataaddr),
        .memwrite   (memwrite),
        .writedata  (writedata),
        .readdata   (readdata),
        .csr_mtie_r (csr_mtie_r),
        .tmr_irq_r  (tmr_irq_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        bit          is_irq;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc_cnt = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: everything tagged for the current cycle is checked here.
    exp_t        mon_e;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
            mon_e   = sb_q.pop_front();
            mon_act = mon_e.is_irq ? {31'b0, tmr_irq_r} : readdata;
            total++;
            if (mon_e.cyc != cyc_cnt) begin
                bad++;
                $display("FAIL %s: stale entry for cycle %0d seen at cycle %0d", mon_e.name, mon_e.cyc, cyc_cnt);
            end else if (mon_act !== mon_e.exp) begin
                bad++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", mon_e.name, mon_act, mon_e.exp);
            end else begin
                $display("ok   %s: 0x%08h", mon_e.name, mon_act);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit is_irq, input logic [31:0] e, input string nm);
        exp_t x;
        x.cyc    = cyc_cnt;
        x.is_irq = is_irq;
        x.exp    = e;
        x.name   = nm;
        sb_q.push_back(x);
    endtask

    task automatic expect_irq(input logic v, input string nm);
        push_exp(1'b1, {31'b0, v}, nm);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
        sel      = 1'b1;
        memwrite = 1'b0;
        dataaddr = {24'b0, a};
        push_exp(1'b0, e, nm);
        tick();
        sel = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        sel       = 1'b1;
        memwrite  = 1'b1;
        dataaddr  = {24'b0, a};
        writedata = d;
        tick();
        sel      = 1'b0;
        memwrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        sel        = 1'b0;
        memwrite   = 1'b0;
        dataaddr   = '0;
        writedata  = '0;
        csr_mtie_r = 1'b0;
        tick();
        tick();
        push_exp(1'b0, 32'h0, "rst_rdata_sel_low");
        expect_irq(1'b0, "rst_irq");
        tick();
        reset      = 1'b1;
        csr_mtie_r = 1'b1;

        // Reset values
        rd(8'h00, 32'h0,        "rst_mtime_lo");
        rd(8'h04, 32'h0,        "rst_mtime_hi");
        rd(8'h08, 32'hFFFFFFFF, "rst_cmp_lo");
        rd(8'h0C, 32'hFFFFFFFF, "rst_cmp_hi");
        rd(8'h10, 32'h0,        "rst_ctrl");
        rd(8'h14, 32'h0,        "rst_status");
        rd(8'h18, 32'h0,        "rst_off18");
        rd(8'h1C, 32'h0,        "rst_off1c");
        for (int i = 0; i < 20; i++) begin
            expect_irq(1'b0, "rst_irq_hold");
            tick();
        end
        wr(8'h14, 32'hFFFFFFFF);
        rd(8'h14, 32'h0, "status_ro");
        wr(8'h18, 32'h12345678);
        rd(8'h18, 32'h0, "off18_ignored");

        // Prescaler EN=1 DIV=3: write edge E0
        wr(8'h10, 32'h0000_0301);
        repeat (3) tick();
        rd(8'h00, 32'd0,  "pre_before_first");  // state after E0+3
        rd(8'h00, 32'd1,  "pre_first_tick");    // E0+4
        repeat (2) tick();
        rd(8'h00, 32'd1,  "pre_before_second"); // E0+7
        rd(8'h00, 32'd2,  "pre_second_tick");   // E0+8
        repeat (91) tick();
        rd(8'h00, 32'd25, "pre_100");           // E0+100
        rd(8'h10, 32'h0000_0301, "ctrl_readback");
        // ctrl write at E0+103 (pre=2 beforehand) restarts the prescaler
        wr(8'h10, 32'h0000_0301);
        rd(8'h00, 32'd25, "restart_hold_a");
        rd(8'h00, 32'd25, "restart_hold_b");
        tick();
        rd(8'h00, 32'd25, "restart_hold_c");
        rd(8'h00, 32'd26, "restart_tick");      // E0+107
        tick();
        tick();
        // ctrl write on the edge where a tick was due
        wr(8'h10, 32'h0000_0301);
        rd(8'h00, 32'd26, "ctrl_wr_suppress");
        wr(8'h10, 32'h0);

        // Carry and wrap, DIV=0
        wr(8'h04, 32'hFFFFFFFF);
        wr(8'h00, 32'hFFFFFFFE);
        wr(8'h10, 32'h1);
        rd(8'h00, 32'hFFFFFFFE, "carry_start_lo");
        rd(8'h04, 32'hFFFFFFFF, "carry_allones_hi");
        rd(8'h04, 32'h0,        "wrap_hi");
        rd(8'h00, 32'h1,        "wrap_lo_one");

        // Write/tick collision
        wr(8'h00, 32'h50);
        rd(8'h00, 32'h50, "coll_no_inc");
        rd(8'h00, 32'h51, "coll_resume_a");
        rd(8'h00, 32'h52, "coll_resume_b");
        wr(8'h10, 32'h0);
        rd(8'h00, 32'h53, "disabled_hold");

        // Interrupt
        wr(8'h00, 32'h0);
        wr(8'h08, 32'h10);
        wr(8'h0C, 32'h0);
        wr(8'h10, 32'h1);                     // edge S
        repeat (15) tick();
        expect_irq(1'b0, "irq_pre");
        rd(8'h00, 32'hF, "irq_mtime_f");      // S+15
        expect_irq(1'b0, "irq_at_equal");
        rd(8'h14, 32'h1, "status_equal");     // S+16
        expect_irq(1'b1, "irq_rise");         // S+17
        wr(8'h08, 32'h100);
        expect_irq(1'b1, "irq_hold_cmp_edge");
        tick();
        expect_irq(1'b0, "irq_drop_cmp");
        wr(8'h08, 32'h10);
        expect_irq(1'b0, "irq_low_before_rise");
        tick();
        expect_irq(1'b1, "irq_rise_again");
        csr_mtie_r = 1'b0;
        tick();
        expect_irq(1'b0, "irq_mtie_drop");
        rd(8'h14, 32'h1, "status_raw_mtie0");
        expect_irq(1'b0, "irq_mtie0_stays");
        tick();

        // Mid-run reset, with a write presented in the same cycle
        csr_mtie_r = 1'b1;
        tick();
        expect_irq(1'b1, "irq_before_reset");
        reset     = 1'b0;
        sel       = 1'b1;
        memwrite  = 1'b1;
        dataaddr  = 32'h0;
        writedata = 32'h77;
        tick();
        sel      = 1'b0;
        memwrite = 1'b0;
        reset    = 1'b1;
        expect_irq(1'b0, "reset_irq");
        rd(8'h00, 32'h0,        "reset_mtime_lo");
        rd(8'h00, 32'h0,        "reset_mtime_hold");
        rd(8'h04, 32'h0,        "reset_mtime_hi");
        rd(8'h10, 32'h0,        "reset_ctrl");
        rd(8'h0C, 32'hFFFFFFFF, "reset_cmp_hi");
        expect_irq(1'b0, "reset_irq_after");
        tick();

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu6_clint_tmr.md
# cpu6_clint_tmr

Memory-mapped machine-timer responder on the cpu6 data bus. It sits on the far side of the core's data-memory port, answering the core's loads and stores to a small register window. It keeps a 64-bit `mtime` counter with a programmable prescaler and compares it against `mtimecmp`. It drives the core's `tmr_irq_r` input, gated by the core's `csr_mtie_r` output.

## Interface
Parameters:
- `CPU6_XLEN`, 32, bus data/address width.
- `PRESCALE_W`, 8, width of the prescaler divider field and counter.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  reset, synchronous and active-low.
- `sel`  input  1  bus select; high when the core's `dataaddr` falls in this block's window.
- `dataaddr`  input  CPU6_XLEN  byte address from the core; only bits [4:2] are decoded.
- `memwrite`  input  1  store strobe from the core (`memwriteM`).
- `writedata`  input  CPU6_XLEN  store data.
- `readdata`  output  CPU6_XLEN  load data.
- `csr_mtie_r`  input  1  mie.MTIE from the core.
- `tmr_irq_r`  output  1  registered timer interrupt to the core.

## Operation
Register map (offset from window base, word access only):
- 0x00 `mtime_lo`, R/W.
- 0x04 `mtime_hi`, R/W.
- 0x08 `mtimecmp_lo`, R/W.
- 0x0C `mtimecmp_hi`, R/W.
- 0x10 `ctrl`, R/W: bit0 = EN; bits [8+PRESCALE_W-1:8] = DIV; all other bits read 0.
- 0x14 `status`, RO: bit0 = raw compare (`mtime >= mtimecmp`, unsigned 64-bit, not gated by MTIE). Writes are ignored.
- Offsets 0x18 and 0x1C: reads return 0, writes are ignored.

Reads and writes:
- A write occurs when `sel & memwrite` at the rising edge.
- `readdata` is combinational from the current register values. It is 0 when `sel` is low.

Prescaler:
- `pre_cnt` has width PRESCALE_W.
- When EN=1: if `pre_cnt == DIV`, then tick, and `pre_cnt <= 0`; otherwise `pre_cnt <= pre_cnt + 1`.
- When EN=0: `pre_cnt` holds and there is no tick.
- DIV=0 ticks every cycle. DIV=N ticks every N+1 cycles.
- Any write to `ctrl` forces `pre_cnt <= 0` in that cycle and suppresses that cycle's tick.

mtime update:
- On a tick, `mtime <= mtime + 1` (64-bit, with carry from lo to hi).
- All-ones wraps to 0.

Write versus tick collision:
- A write to `mtime_lo` replaces the lo half with `writedata`. A write to `mtime_hi` replaces the hi half.
- In a write cycle, the tick is discarded for the whole 64-bit counter: no increment, no carry.
- The prescaler still advances normally.

Interrupt:
- `tmr_irq_r <= (mtime >= mtimecmp) & csr_mtie_r`, evaluated on the register values present before the edge.
- It is level, not pulse. It remains high until software raises `mtimecmp`, rewrites `mtime`, or clears MTIE.

## Timing
Reset values (reset low at a rising edge):
- `mtime` = 0; `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF; `ctrl` = 0 (EN=0, DIV=0); `pre_cnt` = 0; `tmr_irq_r` = 0.
- `readdata` is 0 whenever `sel` is low, including during reset.

Latencies:
- Reset asserted mid-count clears all state at the same edge. No tick or write is applied in that cycle.
- Read latency is 0 cycles (same-cycle combinational).
- A write is visible on `readdata` in the cycle after its edge.
- The first tick after an EN 0→1 write occurs DIV+1 cycles after the write edge.
- Interrupt latency: a compare condition that becomes true at edge k raises `tmr_irq_r` at edge k+1. A `mtimecmp` write that clears the condition at edge k drops `tmr_irq_r` at edge k+1.
- `csr_mtie_r` falling at cycle k (before edge k) drops `tmr_irq_r` at edge k.

Recommended software sequence:
- A 64-bit `mtimecmp` update takes two stores, and the intermediate value is compared.
- To avoid a spurious interrupt, software writes `mtimecmp_hi` = all-ones first, then lo, then hi.

## Test plan
- Reset then read: all registers read their reset values, `mtimecmp` reads 0xFFFFFFFF/0xFFFFFFFF, and `tmr_irq_r`=0 for 20 cycles.
- Prescaler: write `ctrl`=0x0301 (EN=1, DIV=3). `mtime_lo` then reads 1 at 4 cycles after the write, 2 at 8 cycles, and 25 at 100 cycles.
- Carry and wrap: write `mtime_hi`=0xFFFFFFFF and `mtime_lo`=0xFFFFFFFE with DIV=0, EN=1. The counter reads …FFFF, then 0/0, then lo=1 on successive cycles.
- Interrupt: with MTIE=1 and DIV=0, set `mtimecmp`=0x10 (hi=0). `tmr_irq_r` rises exactly one cycle after `mtime` reaches 0x10. Writing `mtimecmp_lo`=0x100 drops it one cycle later. With MTIE=0, status bit0 is 1 but `tmr_irq_r` stays 0.
- Collision: a write of `mtime_lo`=0x50 on a tick cycle reads 0x50 the next cycle (no +1), and normal increments resume afterwards. A write to `ctrl` mid-count restarts the prescaler from 0.
- Mid-run reset: pull reset low for 1 cycle while `tmr_irq_r`=1 and EN=1. All outputs return to reset values at that edge, and the counter stays 0 afterwards.
